// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Purpose  : Word-organised data memory serving the memory-access stage.
//            A level request is accepted in IDLE, the access is held for
//            WAIT_CYCLES wait states, and completion is signalled by a
//            one-cycle mem_ready pulse (with mem_err qualifying it).
//            Misaligned or out-of-range accesses are rejected without
//            touching the storage array.
// Ports    : clk        - clock, rising edge
//            rst_n      - asynchronous active-low reset
//            mem_req    - access request (level, held until mem_ready)
//            mem_we     - 1 = store, 0 = load
//            mem_addr   - byte address
//            mem_wdata  - store data
//            mem_rdata  - load data (held until next load or error)
//            mem_ready  - one-cycle completion pulse
//            mem_err    - access rejected (valid with mem_ready)
//            mem_busy   - high whenever the responder is not idle
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        mem_err,
    output logic        mem_busy
);

    localparam int          c_IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  c_CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [31:0] c_DEPTH    = 32'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [3:0]           r_cnt;
    logic                 r_we;
    logic [31:0]          r_addr;
    logic [31:0]          r_wdata;
    logic [31:0]          r_rdata;
    logic                 r_ready;
    logic                 r_err;
    logic                 r_busy;
    logic [31:0]          r_mem [DEPTH_WORDS];

    logic                 w_accept;
    logic                 w_enter_resp;
    logic                 w_acc_we;
    logic [31:0]          w_acc_addr;
    logic [31:0]          w_acc_wdata;
    logic                 w_err;
    logic [c_IDX_W-1:0]   w_idx;

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (mem_req) begin
                    w_next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next = S_RESP;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_accept     = (r_state == S_IDLE) && mem_req;
    assign w_enter_resp = (w_next == S_RESP);

    // With zero wait states the access happens on the accept edge itself, so
    // the values being captured are taken straight from the inputs.
    assign w_acc_we    = (r_state == S_IDLE) ? mem_we    : r_we;
    assign w_acc_addr  = (r_state == S_IDLE) ? mem_addr  : r_addr;
    assign w_acc_wdata = (r_state == S_IDLE) ? mem_wdata : r_wdata;

    assign w_err = (w_acc_addr[1:0] != 2'b00) ||
                   ({2'b00, w_acc_addr[31:2]} >= c_DEPTH);
    assign w_idx = w_acc_addr[c_IDX_W+1:2];

    // State, handshake and captured-request registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != S_IDLE);
            r_ready <= w_enter_resp;
            r_err   <= w_enter_resp && w_err;

            if (w_accept) begin
                r_we    <= mem_we;
                r_addr  <= mem_addr;
                r_wdata <= mem_wdata;
                r_cnt   <= c_CNT_LOAD;
            end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_enter_resp) begin
                if (w_err) begin
                    r_rdata <= '0;
                end else if (!w_acc_we) begin
                    r_rdata <= r_mem[w_idx];
                end
            end
        end
    end

    // Storage array carries no reset. The rst_n term blocks a write on an
    // edge where reset is still asserted.
    always_ff @(posedge clk) begin
        if (rst_n && w_enter_resp && !w_err && w_acc_we) begin
            r_mem[w_idx] <= w_acc_wdata;
        end
    end

    assign mem_rdata = r_rdata;
    assign mem_ready = r_ready;
    assign mem_err   = r_err;
    assign mem_busy  = r_busy;

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder serving the memory-access (MA) stage: MA supplies address, store data and write enable; this block performs the access.
- Word-organised storage with a configurable number of wait states.
- Level request / one-cycle ready handshake, so the pipeline can stall on slow memory.
- Flags misaligned and out-of-range accesses instead of corrupting storage.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words stored; valid byte addresses are 0 to 4*DEPTH_WORDS-4.
- WAIT_CYCLES, 2, cycles spent in WAIT before the response; 0 is legal; maximum 15.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mem_req  input  1  access request, level; held by MA until mem_ready is seen.
- mem_we  input  1  1 = store, 0 = load; driven from MA write enable.
- mem_addr  input  32  byte address; driven from MA ALU result (MAR).
- mem_wdata  input  32  store data; driven from MA MDR.
- mem_rdata  output  32  load data; feeds MA readData.
- mem_ready  output  1  one-cycle completion pulse.
- mem_err  output  1  qualifies mem_ready: access rejected.
- mem_busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (asynchronous, rst_n low):
  - State goes to IDLE.
  - mem_rdata=0, mem_ready=0, mem_err=0, mem_busy=0.
  - Wait counter and captured request registers are cleared.
  - The storage array is not reset; its contents are undefined until written.
- States are IDLE, WAIT and RESP.
- IDLE:
  - If mem_req=1 at an edge (the accept edge E0), capture mem_we, mem_addr and mem_wdata.
  - If WAIT_CYCLES=0, go to RESP.
  - Otherwise go to WAIT with the counter loaded to WAIT_CYCLES-1.
- WAIT:
  - Counter decrements each edge.
  - Transition to RESP on the edge where the counter is 0.
  - Exactly WAIT_CYCLES cycles are spent in WAIT.
- Access, performed on the edge that enters RESP, using only the captured values:
  - Error when captured addr[1:0]!=0 or addr[31:2]>=DEPTH_WORDS. On error: no write, mem_rdata=0, mem_err=1.
  - Valid store: array[addr[31:2]] <= wdata. mem_rdata is unchanged. mem_err=0.
  - Valid load: mem_rdata <= array[addr[31:2]]. mem_err=0.
- RESP:
  - mem_ready=1 for exactly one cycle; mem_err is valid in the same cycle.
  - Unconditional transition to IDLE.
- Latency: mem_ready is high in the cycle after edge E0+WAIT_CYCLES, i.e. WAIT_CYCLES+1 cycles after acceptance.
- Throughput: at most one access per WAIT_CYCLES+2 cycles, because RESP always returns through IDLE.
- Handshake rules:
  - MA holds mem_req high until it samples mem_ready=1, then deasserts on that same edge.
  - mem_req seen in IDLE after RESP starts a new access.
  - mem_req, mem_addr, mem_wdata and mem_we changes while busy are ignored; the captured values are used.
- mem_rdata holds its value until the next valid load or error completion.
- Read-after-write: a load accepted after a store's mem_ready returns the new data.
- Reset mid-operation (in WAIT or RESP):
  - Abort to IDLE immediately; mem_ready drops asynchronously.
  - A store still in WAIT is discarded; the array is unmodified.
- mem_busy = (state != IDLE), registered with the state.

Test Plan:
- Store then load, WAIT_CYCLES=2:
  - Store: addr=0x10, wdata=0xDEADBEEF → mem_ready high exactly 3 cycles after accept, mem_err=0.
  - Then load addr=0x10 → mem_rdata=0xDEADBEEF with mem_ready.
- WAIT_CYCLES=0 back-to-back loads, addresses 0x0 then 0x4 (preloaded 0x11, 0x22):
  - mem_ready is high the cycle after each accept; accepts are 2 cycles apart.
  - mem_rdata reads 0x11, then 0x22.
- Misaligned store to addr=0x13 with wdata=0x5 → mem_ready=1, mem_err=1, mem_rdata=0; a following load of 0x10 returns the old contents.
- Out-of-range load, DEPTH_WORDS=1024, addr=0x1000 → mem_err=1 with mem_ready, mem_rdata=0.
- Input changes while busy:
  - Accept store addr=0x20, data=0xA; during WAIT change addr to 0x24 and data to 0xB.
  - Word 0x20 gets 0xA; word 0x24 is unchanged.
- Reset mid-operation:
  - Accept store 0x30=0x77 and assert rst_n=0 during WAIT → mem_busy=0 and mem_ready=0 immediately.
  - After release, a load of 0x30 returns the prior value, not 0x77.
